// File: rtl/data_demux_module.sv
// data_demux_module: frame-aligned 1:3 symbol demultiplexer.
// Ports: symbol_clk/rst_n, mode, switch_clk_cycles (N), data_in,
//   in_valid, sync in; DS1..3_out + ds1..3_valid, locked, frame_err out.
// Optional DEMUX_STATS_EN adds 16-bit saturating ds1..3_cnt outputs.
module data_demux_module (
  input  logic        symbol_clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic [2:0]  switch_clk_cycles,
  input  logic [7:0]  data_in,
  input  logic        in_valid,
  input  logic        sync,
  output logic [7:0]  DS1_out,
  output logic [7:0]  DS2_out,
  output logic [7:0]  DS3_out,
  output logic        ds1_valid,
  output logic        ds2_valid,
  output logic        ds3_valid,
  output logic        locked,
  output logic        frame_err
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0] ds1_cnt,
  output logic [15:0] ds2_cnt,
  output logic [15:0] ds3_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HUNT,
    S_LOCKED
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  mode_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  ds1_q, ds1_d;
  logic [7:0]  ds2_q, ds2_d;
  logic [7:0]  ds3_q, ds3_d;
  logic        v1_q, v1_d;
  logic        v2_q, v2_d;
  logic        v3_q, v3_d;
  logic        ferr_q, ferr_d;

  logic        mode_chg;
  logic        deliver;
  logic        ferr;
  logic [2:0]  idx3;
  logic [3:0]  idx;
  logic [3:0]  n4;
  logic [3:0]  n2;
  logic [3:0]  n3;
  logic [3:0]  n23;
  logic [1:0]  sel;

  always_comb begin
    mode_chg = (mode != mode_q);
    n4       = {1'b0, switch_clk_cycles};
    n2       = n4 / 4'd2;
    n3       = n4 / 4'd3;
    n23      = (n4 + n4) / 4'd3;
    idx3     = sync ? 3'd0 : cnt_q;
    idx      = {1'b0, idx3};
    ferr     = (state_q == S_LOCKED) && !mode_chg && in_valid
               && sync && (cnt_q != 3'd0);

    case (mode)
      2'b01:   sel = 2'd1;
      2'b10:   sel = (idx < n2) ? 2'd1 : 2'd2;
      2'b11:   sel = (idx < n3)  ? 2'd1 :
                     (idx < n23) ? 2'd2 : 2'd3;
      default: sel = 2'd0;
    endcase
    // a realigning sync is always slot 0 of a new frame -> DS1
    if (ferr) sel = 2'd1;

    state_d = state_q;
    cnt_d   = cnt_q;
    ds1_d   = ds1_q;
    ds2_d   = ds2_q;
    ds3_d   = ds3_q;
    v1_d    = 1'b0;
    v2_d    = 1'b0;
    v3_d    = 1'b0;
    ferr_d  = ferr;
    deliver = 1'b0;

    if (mode_chg) begin
      state_d = (mode == 2'b00) ? S_IDLE : S_HUNT;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = 3'd0;
          if (mode != 2'b00) state_d = S_HUNT;
        end
        S_HUNT: begin
          if (mode == 2'b00) begin
            state_d = S_IDLE;
          end else if (in_valid && sync) begin
            state_d = S_LOCKED;
            deliver = 1'b1;
          end
        end
        S_LOCKED: begin
          if (mode == 2'b00) state_d = S_IDLE;
          else if (in_valid) deliver = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (deliver) begin
      if (n4 <= 4'd1 || idx >= n4 - 4'd1) cnt_d = 3'd0;
      else cnt_d = idx3 + 3'd1;
      unique case (1'b1)
        (sel == 2'd1): begin ds1_d = data_in; v1_d = 1'b1; end
        (sel == 2'd2): begin ds2_d = data_in; v2_d = 1'b1; end
        (sel == 2'd3): begin ds3_d = data_in; v3_d = 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge symbol_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      cnt_q   <= 3'd0;
      ds1_q   <= 8'h00;
      ds2_q   <= 8'h00;
      ds3_q   <= 8'h00;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode;
      cnt_q   <= cnt_d;
      ds1_q   <= ds1_d;
      ds2_q   <= ds2_d;
      ds3_q   <= ds3_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      ferr_q  <= ferr_d;
    end
  end

  assign DS1_out   = ds1_q;
  assign DS2_out   = ds2_q;
  assign DS3_out   = ds3_q;
  assign ds1_valid = v1_q;
  assign ds2_valid = v2_q;
  assign ds3_valid = v3_q;
  assign locked    = (state_q == S_LOCKED);
  assign frame_err = ferr_q;

`ifdef DEMUX_STATS_EN
  logic [15:0] c1_q, c1_d;
  logic [15:0] c2_q, c2_d;
  logic [15:0] c3_q, c3_d;

  function automatic logic [15:0] bump(
    input logic [15:0] c,
    input logic        hit
  );
    if (hit && c != 16'hFFFF) return c + 16'd1;
    return c;
  endfunction

  always_comb begin
    c1_d = bump(c1_q, v1_d);
    c2_d = bump(c2_q, v2_d);
    c3_d = bump(c3_q, v3_d);
    if (mode_chg) begin
      c1_d = 16'd0;
      c2_d = 16'd0;
      c3_d = 16'd0;
    end
  end

  always_ff @(posedge symbol_clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_q <= 16'd0;
      c2_q <= 16'd0;
      c3_q <= 16'd0;
    end else begin
      c1_q <= c1_d;
      c2_q <= c2_d;
      c3_q <= c3_d;
    end
  end

  assign ds1_cnt = c1_q;
  assign ds2_cnt = c2_q;
  assign ds3_cnt = c3_q;
`endif

endmodule

// File: tb/tb_data_demux_module.sv
// tb_data_demux_module: scoreboard bench for data_demux_module.
// Directed frame scenarios plus randomized traffic vs a reference model.
module tb_data_demux_module;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [2:0]  switch_clk_cycles;
  logic [7:0]  data_in;
  logic        in_valid;
  logic        sync;
  logic [7:0]  DS1_out, DS2_out, DS3_out;
  logic        ds1_valid, ds2_valid, ds3_valid;
  logic        locked;
  logic        frame_err;
`ifdef DEMUX_STATS_EN
  logic [15:0] ds1_cnt, ds2_cnt, ds3_cnt;
`endif

  data_demux_module dut (
    .symbol_clk        (clk),
    .rst_n             (rst_n),
    .mode              (mode),
    .switch_clk_cycles (switch_clk_cycles),
    .data_in           (data_in),
    .in_valid          (in_valid),
    .sync              (sync),
    .DS1_out           (DS1_out),
    .DS2_out           (DS2_out),
    .DS3_out           (DS3_out),
    .ds1_valid         (ds1_valid),
    .ds2_valid         (ds2_valid),
    .ds3_valid         (ds3_valid),
    .locked            (locked),
    .frame_err         (frame_err)
`ifdef DEMUX_STATS_EN
    ,
    .ds1_cnt           (ds1_cnt),
    .ds2_cnt           (ds2_cnt),
    .ds3_cnt           (ds3_cnt)
`endif
  );

  typedef struct {
    int         s;
    logic [7:0] d;
    bit         e;
    int         c;
  } exp_t;

  exp_t       q[$];
  int         obs[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ferr_seen = 0;
  logic [7:0] exp_ds[1:3];

  // reference model state
  bit         m_lk = 0;
  int         m_slot = 0;
  logic [1:0] m_pmode = 2'b00;
  logic [1:0] t_mode = 2'b00;
  logic [2:0] t_n = 3'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int route(int md, int n, int idx);
    if (md == 1) return 1;
    if (md == 2) return (idx < n / 2) ? 1 : 2;
    if (idx < n / 3) return 1;
    if (idx < 2 * n / 3) return 2;
    return 3;
  endfunction

  task automatic model_step();
    int idx;
    int st;
    int n;
    bit err;
    bit dlv;
    idx = 0;
    err = 0;
    dlv = 0;
    n = int'(switch_clk_cycles);
    if (mode != m_pmode) begin
      m_lk = 0;
      m_slot = 0;
    end else if (mode != 2'b00) begin
      if (!m_lk) begin
        if (in_valid && sync) begin
          m_lk = 1;
          dlv = 1;
        end
      end else if (in_valid) begin
        dlv = 1;
        idx = sync ? 0 : m_slot;
        err = sync && (m_slot != 0);
      end
    end
    m_pmode = mode;
    if (dlv) begin
      st = err ? 1 : route(int'(mode), n, idx);
      q.push_back('{st, data_in, err, cyc});
      m_slot = (n <= 1 || idx >= n - 1) ? 0 : idx + 1;
    end
  endtask

  task automatic sym(input bit v, input bit s, input logic [7:0] d);
    @(posedge clk);
    #1;
    checks++;
    if (locked !== m_lk) begin
      errors++;
      $display("FAIL locked cyc=%0d got=%0b exp=%0b", cyc, locked, m_lk);
    end
    in_valid = v;
    sync = s;
    data_in = d;
    mode = t_mode;
    switch_clk_cycles = t_n;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sym(0, 0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sync = 1'b0;
    #1;
    checks++;
    if ({DS1_out, DS2_out, DS3_out} !== 24'h0 ||
        {ds1_valid, ds2_valid, ds3_valid} !== 3'b000 ||
        locked !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ds=%h/%h/%h v=%b%b%b lk=%b fe=%b exp=0",
               DS1_out, DS2_out, DS3_out, ds1_valid, ds2_valid,
               ds3_valid, locked, frame_err);
    end
`ifdef DEMUX_STATS_EN
    checks++;
    if ({ds1_cnt, ds2_cnt, ds3_cnt} !== 48'h0) begin
      errors++;
      $display("FAIL reset_cnt got=%h/%h/%h exp=0",
               ds1_cnt, ds2_cnt, ds3_cnt);
    end
`endif
    q.delete();
    m_lk = 0;
    m_slot = 0;
    m_pmode = 2'b00;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode = t_mode;
    switch_clk_cycles = t_n;
    model_step();
  endtask

  task automatic check_list(input string nm, input int exp_l[$]);
    checks++;
    if (obs != exp_l) begin
      errors++;
      $display("FAIL %s got=%p exp=%p", nm, obs, exp_l);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a strobe
  always @(negedge clk) begin
    int nv;
    int sa;
    exp_t e;
    if (!rst_n) begin
      exp_ds[1] = 8'h00;
      exp_ds[2] = 8'h00;
      exp_ds[3] = 8'h00;
    end else begin
      while (q.size() != 0 && q[0].c + 1 < cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_valid cyc=%0d got=none exp=DS%0d:%h",
                 cyc, e.s, e.d);
      end
      nv = int'(ds1_valid) + int'(ds2_valid) + int'(ds3_valid);
      sa = ds1_valid ? 1 : ds2_valid ? 2 : ds3_valid ? 3 : 0;
      if (frame_err) ferr_seen++;
      if (nv > 1) begin
        checks++;
        errors++;
        $display("FAIL multi_valid cyc=%0d got=%0d exp=1", cyc, nv);
      end
      if (nv != 0 || frame_err) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious cyc=%0d got=DS%0d fe=%b exp=none",
                   cyc, sa, frame_err);
        end else begin
          e = q.pop_front();
          if (sa != e.s || frame_err != e.e || e.c + 1 != cyc ||
              (sa != 0 && (sa == 1 ? DS1_out : sa == 2 ? DS2_out
                                   : DS3_out) !== e.d)) begin
            errors++;
            $display("FAIL deliver cyc=%0d got=DS%0d fe=%b exp=DS%0d:%h fe=%b",
                     cyc, sa, frame_err, e.s, e.d, e.e);
          end
          exp_ds[e.s] = e.d;
          obs.push_back(e.s * 256 + int'(e.d));
        end
      end
      checks++;
      if (DS1_out !== exp_ds[1] || DS2_out !== exp_ds[2] ||
          DS3_out !== exp_ds[3]) begin
        errors++;
        $display("FAIL hold cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc,
                 DS1_out, DS2_out, DS3_out,
                 exp_ds[1], exp_ds[2], exp_ds[3]);
      end
    end
  end

  initial begin
    int exp_l[$];
    int f0;
    rst_n = 1'b0;
    mode = 2'b00;
    switch_clk_cycles = 3'd0;
    data_in = 8'h00;
    in_valid = 1'b0;
    sync = 1'b0;
    do_reset(3);
    idle(2);

    // three streams, N=6
    t_mode = 2'b11;
    t_n = 3'd6;
    idle(2);
    obs.delete();
    sym(1, 1, 8'h10);
    for (int i = 1; i < 6; i++) sym(1, 0, 8'h10 + 8'(i));
    idle(2);
    exp_l = '{'h110, 'h111, 'h212, 'h213, 'h314, 'h315};
    check_list("three_stream", exp_l);

    // two streams, N=4
    t_mode = 2'b10;
    t_n = 3'd4;
    idle(2);
    obs.delete();
    sym(1, 1, 8'hA0);
    for (int i = 1; i < 8; i++) sym(1, 0, 8'hA0 + 8'(i));
    idle(2);
    exp_l = '{'h1A0, 'h1A1, 'h2A2, 'h2A3, 'h1A4, 'h1A5, 'h2A6, 'h2A7};
    check_list("two_stream", exp_l);

    // misaligned sync at counter 3
    t_mode = 2'b11;
    t_n = 3'd6;
    idle(2);
    obs.delete();
    f0 = ferr_seen;
    sym(1, 1, 8'h30);
    sym(1, 0, 8'h31);
    sym(1, 0, 8'h32);
    sym(1, 1, 8'h33);
    sym(1, 0, 8'h34);
    sym(1, 0, 8'h35);
    idle(2);
    exp_l = '{'h130, 'h131, 'h232, 'h133, 'h134, 'h235};
    check_list("frame_err_route", exp_l);
    checks++;
    if (ferr_seen - f0 != 1) begin
      errors++;
      $display("FAIL frame_err_count got=%0d exp=1", ferr_seen - f0);
    end

    // mode 11 -> 01 mid-frame
    idle(1);
    obs.delete();
    sym(1, 1, 8'h40);
    sym(1, 0, 8'h41);
    sym(1, 0, 8'h42);
    t_mode = 2'b01;
    sym(1, 0, 8'h43);
    sym(1, 0, 8'h44);
    sym(1, 1, 8'h45);
    sym(1, 0, 8'h46);
    sym(1, 0, 8'h47);
    idle(2);
    exp_l = '{'h140, 'h141, 'h242, 'h145, 'h146, 'h147};
    check_list("mode_switch", exp_l);

    // reset while locked at counter 4
    t_mode = 2'b11;
    t_n = 3'd6;
    idle(2);
    obs.delete();
    sym(1, 1, 8'h50);
    sym(1, 0, 8'h51);
    sym(1, 0, 8'h52);
    sym(1, 0, 8'h53);
    do_reset(2);
    sym(1, 0, 8'h60);
    sym(1, 0, 8'h61);
    sym(1, 1, 8'h62);
    idle(2);
    exp_l = '{'h150, 'h151, 'h252, 'h162};
    check_list("reset_mid_frame", exp_l);

`ifdef DEMUX_STATS_EN
    t_mode = 2'b10;
    idle(1);
    t_mode = 2'b11;
    t_n = 3'd3;
    idle(1);
    sym(1, 1, 8'h00);
    for (int i = 1; i < 30; i++) sym(1, 0, 8'(i));
    idle(2);
    checks++;
    if (ds1_cnt != 16'd10 || ds2_cnt != 16'd10 || ds3_cnt != 16'd10) begin
      errors++;
      $display("FAIL stats got=%0d/%0d/%0d exp=10/10/10",
               ds1_cnt, ds2_cnt, ds3_cnt);
    end
`endif

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) t_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) t_n = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 399) == 0) begin
        do_reset(2);
      end else begin
        sym($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
            8'($urandom));
      end
    end
    idle(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_demux_module.md
DATA_DEMUX_MODULE -- requirements
Module: data_demux_module

Interface
REQ-001 Parameter: none; all widths fixed as stated below.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, as follows:
- symbol_clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have these data and control ports:
- mode  in  2  01 = one stream, 10 = two streams, 11 = three streams, 00 = idle.
- switch_clk_cycles  in  3  frame length N, in symbols.
- data_in  in  8  muxed symbol stream.
- in_valid  in  1  data_in qualifier.
- sync  in  1  frame-start marker; the qualified symbol carrying it is slot 0.
- DS1_out / DS2_out / DS3_out  out  8 each  demuxed streams, registered.
- ds1_valid / ds2_valid / ds3_valid  out  1 each  one-cycle strobes.
- locked  out  1  high in LOCKED state.
- frame_err  out  1  one-cycle pulse on misaligned sync.

Function
REQ-004 The FSM SHALL have states IDLE, HUNT and LOCKED.
- IDLE is entered when mode==00.
- IDLE->HUNT when mode!=00.
- HUNT->LOCKED on in_valid&sync.
REQ-005 Any change of mode from its previous-cycle value SHALL force HUNT, or IDLE if the new mode is 00, on the next edge.
- The slot counter SHALL clear on that edge.
REQ-006 The slot counter SHALL be 3 bits wide.
- It SHALL advance only on in_valid.
- Slot index idx = sync ? 0 : counter.
- Next counter = (idx >= N-1) ? 0 : idx+1.
- N of 0 or 1 SHALL hold the counter at 0.
REQ-007 The slot decode SHALL use integer division with at least 4-bit intermediates.
- mode 01: every slot goes to DS1.
- mode 10: idx < N/2 goes to DS1, else DS2.
- mode 11: idx < N/3 goes to DS1; else idx < 2N/3 goes to DS2; else DS3.
REQ-008 In LOCKED with in_valid, the selected DSx_out SHALL load data_in and the matching dsx_valid SHALL pulse on the next edge.
- Latency is 1 cycle.
- Exactly one valid SHALL pulse per qualified symbol.
- The unselected outputs SHALL hold their values.
REQ-009 In IDLE or HUNT, no dsx_valid SHALL assert and all DSx_out SHALL hold.
- The symbol carrying sync in HUNT SHALL be decoded as slot 0 on the same edge that enters LOCKED.
REQ-010 In LOCKED, in_valid&sync with counter!=0 SHALL pulse frame_err and realign to slot 0.
- That symbol SHALL still be delivered, to DS1.
REQ-011 sync without in_valid SHALL be ignored.
REQ-012 A change of switch_clk_cycles while LOCKED SHALL take effect on the next symbol with no realignment.
- Counter >= N-1 SHALL wrap to 0.

Reset
REQ-013 While rst_n=0 the block SHALL be in IDLE with counter=0, DSx_out=8'h00, and all valid, locked and frame_err outputs at 0.
REQ-014 Reset mid-frame SHALL discard the partial frame.
- After release, the block SHALL return to HUNT and wait for a new sync.

Configuration
REQ-015 Macro DEMUX_STATS_EN SHALL control per-stream statistics.
- Defined: adds outputs ds1_cnt, ds2_cnt and ds3_cnt, each 16 bits.
- Each counter SHALL count its dsx_valid pulses, saturate at 16'hFFFF, and clear on reset and on mode change.
- Undefined: these ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- mode=11, N=6, sync on sym0, in_valid continuous, data 0x10..0x15: DS1 gets 0x10,0x11; DS2 gets 0x12,0x13; DS3 gets 0x14,0x15; each 1 cycle late.
- mode=10, N=4, data 0xA0..0xA7: DS1 gets A0,A1,A4,A5; DS2 gets A2,A3,A6,A7.
- mode=11, N=6, extra sync at counter=3: frame_err pulses once; that symbol goes to DS1; the next two symbols go to DS1 then DS2.
- mode switches 11->01 mid-frame: no valid until next sync; then every symbol goes to DS1.
- rst_n low while LOCKED at counter=4: outputs clear immediately; no valid after release until sync.
- With DEMUX_STATS_EN, mode=11, N=3, 30 symbols: ds1_cnt=ds2_cnt=ds3_cnt=10.
